// File: rtl/fft_peak_detect.sv
// Scans one 16-bin FFT frame per acceptance and reports the bin with the largest
// squared magnitude, one bin per clock, with a sticky flag for frames that arrive mid-scan.
module fft_peak_detect (
  input  logic        clk,
  input  logic        rst,
  input  logic        fft_valid,
  input  logic [31:0] fft_d0,
  input  logic [31:0] fft_d1,
  input  logic [31:0] fft_d2,
  input  logic [31:0] fft_d3,
  input  logic [31:0] fft_d4,
  input  logic [31:0] fft_d5,
  input  logic [31:0] fft_d6,
  input  logic [31:0] fft_d7,
  input  logic [31:0] fft_d8,
  input  logic [31:0] fft_d9,
  input  logic [31:0] fft_d10,
  input  logic [31:0] fft_d11,
  input  logic [31:0] fft_d12,
  input  logic [31:0] fft_d13,
  input  logic [31:0] fft_d14,
  input  logic [31:0] fft_d15,
  output logic        done,
  output logic [3:0]  freq,
  output logic [31:0] peak_mag,
  output logic        busy,
  output logic        drop_err
);

  localparam int unsigned NBINS  = 16;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned HALF_W = 16;
  localparam int unsigned IDX_W  = 4;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [WORD_W-1:0]   buf_q [NBINS];
  logic [WORD_W-1:0]   buf_d [NBINS];
  logic [WORD_W-1:0]   max_q, max_d;
  logic [IDX_W-1:0]    max_idx_q, max_idx_d;
  logic [IDX_W-1:0]    freq_q, freq_d;
  logic [WORD_W-1:0]   peak_q, peak_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                drop_q, drop_d;

  logic [WORD_W-1:0]   din [NBINS];
  logic [WORD_W-1:0]   cur_word;
  logic [WORD_W-1:0]   re_ext, im_ext, cur_mag;
  logic                take;

  assign din[0]  = fft_d0;
  assign din[1]  = fft_d1;
  assign din[2]  = fft_d2;
  assign din[3]  = fft_d3;
  assign din[4]  = fft_d4;
  assign din[5]  = fft_d5;
  assign din[6]  = fft_d6;
  assign din[7]  = fft_d7;
  assign din[8]  = fft_d8;
  assign din[9]  = fft_d9;
  assign din[10] = fft_d10;
  assign din[11] = fft_d11;
  assign din[12] = fft_d12;
  assign din[13] = fft_d13;
  assign din[14] = fft_d14;
  assign din[15] = fft_d15;

  // Squares of sign-extended 8.8 parts are non-negative, so modulo-2^32 products are exact.
  always_comb begin
    cur_word = buf_q[idx_q];
    re_ext   = {{HALF_W{cur_word[WORD_W-1]}}, cur_word[WORD_W-1:HALF_W]};
    im_ext   = {{HALF_W{cur_word[HALF_W-1]}}, cur_word[HALF_W-1:0]};
    cur_mag  = WORD_W'(re_ext * re_ext) + WORD_W'(im_ext * im_ext);
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    buf_d     = buf_q;
    max_d     = max_q;
    max_idx_d = max_idx_q;
    freq_d    = freq_q;
    peak_d    = peak_q;
    drop_d    = drop_q;
    take      = (idx_q == '0) || (cur_mag > max_q);

    unique case (state_q)
      IDLE, DONE: begin
        if (fft_valid) begin
          buf_d   = din;
          idx_d   = '0;
          state_d = SCAN;
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        if (fft_valid) drop_d = 1'b1;
        if (take) begin
          max_d     = cur_mag;
          max_idx_d = idx_q;
        end
        idx_d = IDX_W'(idx_q + 1'b1);
        // Outputs see only the final winner, never the running max.
        if (idx_q == IDX_W'(NBINS - 1)) begin
          state_d = DONE;
          freq_d  = take ? idx_q : max_idx_q;
          peak_d  = take ? cur_mag : max_q;
        end
      end
      default: state_d = IDLE;
    endcase

    done_d = (state_d == DONE);
    busy_d = (state_d == SCAN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      buf_q     <= '{default: '0};
      max_q     <= '0;
      max_idx_q <= '0;
      freq_q    <= '0;
      peak_q    <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      buf_q     <= buf_d;
      max_q     <= max_d;
      max_idx_q <= max_idx_d;
      freq_q    <= freq_d;
      peak_q    <= peak_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      drop_q    <= drop_d;
    end
  end

  assign done     = done_q;
  assign freq     = freq_q;
  assign peak_mag = peak_q;
  assign busy     = busy_q;
  assign drop_err = drop_q;

endmodule

// File: tb/tb_fft_peak_detect.sv
// Directed and randomized frames for fft_peak_detect, checked against an arithmetic peak model.
module tb_fft_peak_detect;

  logic        clk;
  logic        rst;
  logic        fft_valid;
  logic [31:0] din [16];
  logic        done;
  logic [3:0]  freq;
  logic [31:0] peak_mag;
  logic        busy;
  logic        drop_err;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] frm [16];
  logic [3:0]  prev_f;
  logic [31:0] prev_p;
  logic        exp_drop;

  fft_peak_detect dut (
    .clk(clk), .rst(rst), .fft_valid(fft_valid),
    .fft_d0(din[0]),   .fft_d1(din[1]),   .fft_d2(din[2]),   .fft_d3(din[3]),
    .fft_d4(din[4]),   .fft_d5(din[5]),   .fft_d6(din[6]),   .fft_d7(din[7]),
    .fft_d8(din[8]),   .fft_d9(din[9]),   .fft_d10(din[10]), .fft_d11(din[11]),
    .fft_d12(din[12]), .fft_d13(din[13]), .fft_d14(din[14]), .fft_d15(din[15]),
    .done(done), .freq(freq), .peak_mag(peak_mag), .busy(busy), .drop_err(drop_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer |z|^2 per bin, first strictly larger wins.
  task automatic model(output logic [3:0] f, output logic [31:0] p);
    longint best;
    longint m;
    int re, im;
    best = -1;
    f = '0;
    for (int k = 0; k < 16; k++) begin
      re = $signed(frm[k][31:16]);
      im = $signed(frm[k][15:0]);
      m  = longint'(re) * re + longint'(im) * im;
      if (m > best) begin
        best = m;
        f = 4'(k);
      end
    end
    p = 32'(best);
  endtask

  task automatic drive_frame();
    fft_valid = 1'b1;
    for (int k = 0; k < 16; k++) din[k] = frm[k];
  endtask

  task automatic drive_idle();
    fft_valid = 1'b0;
    for (int k = 0; k < 16; k++) din[k] = 'x;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_outs(input string tag, input logic eb, input logic ed);
    chk({tag, "_busy"}, 32'(busy), 32'(eb));
    chk({tag, "_done"}, 32'(done), 32'(ed));
    chk({tag, "_freq"}, 32'(freq), 32'(prev_f));
    chk({tag, "_peak"}, peak_mag, prev_p);
    chk({tag, "_drop"}, 32'(drop_err), 32'(exp_drop));
  endtask

  // Called at a negedge; returns at the negedge after E16 (done expected high).
  task automatic run_frame(input string tag, input int drop_at);
    logic [3:0]  ef;
    logic [31:0] ep;
    model(ef, ep);
    drive_frame();
    step();
    drive_idle();
    check_outs({tag, "_e0"}, 1'b1, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      if (k == drop_at) begin
        fft_valid = 1'b1;
        for (int j = 0; j < 16; j++) din[j] = $urandom;
      end
      step();
      drive_idle();
      if (k == drop_at) exp_drop = 1'b1;
      if (k < 16) begin
        if (k == 8 || k == 15 || k == drop_at) check_outs({tag, "_mid"}, 1'b1, 1'b0);
      end else begin
        prev_f = ef;
        prev_p = ep;
        check_outs({tag, "_e16"}, 1'b0, 1'b1);
      end
    end
  endtask

  task automatic finish_frame(input string tag);
    step();
    check_outs({tag, "_e17"}, 1'b0, 1'b0);
  endtask

  task automatic fill(input logic [31:0] v);
    for (int k = 0; k < 16; k++) frm[k] = v;
  endtask

  initial begin
    logic [31:0] small_vals [4];
    small_vals[0] = 32'h0000_0000;
    small_vals[1] = 32'h0000_0001;
    small_vals[2] = 32'h0001_0000;
    small_vals[3] = 32'h0000_FFFF;

    rst = 1'b1;
    drive_idle();
    prev_f = '0;
    prev_p = '0;
    exp_drop = 1'b0;
    repeat (3) step();
    check_outs("reset", 1'b0, 1'b0);
    rst = 1'b0;

    // Single peak at bin 0; accepted on the first edge after reset release.
    fill(32'h0);
    frm[0] = 32'h0100_0000;
    run_frame("single", 0);
    chk("single_freq_const", 32'(freq), 32'h0);
    chk("single_peak_const", peak_mag, 32'h0001_0000);
    finish_frame("single");
    repeat (3) begin
      step();
      check_outs("hold", 1'b0, 1'b0);
    end

    // Signed parts, small-magnitude background.
    for (int k = 0; k < 16; k++) frm[k] = small_vals[$urandom_range(0, 3)];
    frm[5] = 32'h0200_FE00;
    run_frame("signed", 0);
    chk("signed_freq_const", 32'(freq), 32'd5);
    chk("signed_peak_const", peak_mag, 32'h0008_0000);
    finish_frame("signed");

    // Tie: lower index must win.
    fill(32'h0);
    frm[3] = 32'h0300_0000;
    frm[9] = 32'h0300_0000;
    run_frame("tie", 0);
    chk("tie_freq_const", 32'(freq), 32'd3);
    finish_frame("tie");

    // Extreme negative corner in the last bin.
    fill(32'h7FFF_0000);
    frm[15] = 32'h8000_8000;
    run_frame("extreme", 0);
    chk("extreme_freq_const", 32'(freq), 32'd15);
    chk("extreme_peak_const", peak_mag, 32'h8000_0000);
    finish_frame("extreme");

    // Dropped frame at E8, then back-to-back accept at E17.
    for (int k = 0; k < 16; k++) frm[k] = $urandom;
    run_frame("drop", 8);
    for (int k = 0; k < 16; k++) frm[k] = $urandom;
    run_frame("b2b", 0);
    chk("b2b_drop_sticky", 32'(drop_err), 32'h1);
    finish_frame("b2b");

    // Asynchronous reset between edges clears outputs immediately.
    #2 rst = 1'b1;
    #1;
    prev_f = '0;
    prev_p = '0;
    exp_drop = 1'b0;
    check_outs("async_rst", 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    begin
      int seen_done = 0;
      repeat (30) begin
        step();
        if (done !== 1'b0) seen_done++;
      end
      chk("idle30_done", 32'(seen_done), 32'd0);
    end

    // Reset pulse at E10 of a scan aborts it.
    for (int k = 0; k < 16; k++) frm[k] = $urandom;
    drive_frame();
    step();
    drive_idle();
    repeat (9) step();
    rst = 1'b1;
    #1 check_outs("midrst", 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) begin
      step();
      chk("midrst_no_done", 32'(done), 32'h0);
    end
    check_outs("midrst_after", 1'b0, 1'b0);
    for (int k = 0; k < 16; k++) frm[k] = $urandom;
    run_frame("postrst", 0);
    finish_frame("postrst");

    // Randomized frames, some with forced ties and back-to-back chaining.
    for (int n = 0; n < 20; n++) begin
      for (int k = 0; k < 16; k++) begin
        if ($urandom_range(0, 3) == 0) frm[k] = frm[$urandom_range(0, 15)];
        else frm[k] = $urandom;
      end
      run_frame("rand", ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 15)) : 0);
      if ($urandom_range(0, 1) == 0) finish_frame("rand");
    end
    finish_frame("last");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fft_peak_detect.md
FFT_PEAK_DETECT -- requirements
Module: fft_peak_detect

Interface
REQ-001 The block SHALL have no parameters; the bin count is fixed at 16 and the magnitude width at 32 bits.
REQ-002 clk  input  1  Single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  Reset; asynchronous, active-high.
REQ-004 fft_valid  input  1  One-cycle strobe: fft_d0..fft_d15 carry one complete FFT frame.
REQ-005 fft_d0..fft_d15  input  32 each  Bin k: [31:16] is signed real part, [15:0] is signed imaginary part, both in 8.8 format.
REQ-006 done  output  1  One-cycle pulse: freq and peak_mag are updated for the last accepted frame.
REQ-007 freq  output  4  Index of the bin with the largest magnitude.
REQ-008 peak_mag  output  32  Largest magnitude squared, re^2+im^2, unsigned.
REQ-009 busy  output  1  High while a frame is being scanned.
REQ-010 drop_err  output  1  Sticky flag: a frame was dropped.

Function
REQ-011 The FSM SHALL have the states IDLE, SCAN and DONE.
REQ-012 The block SHALL accept a frame only when fft_valid=1 at a clock edge while the FSM is in IDLE or DONE.
- On acceptance, all 16 words SHALL be captured into an internal buffer.
- The bin index SHALL be set to 0 and the FSM SHALL go to SCAN.
REQ-013 In SCAN, each edge SHALL evaluate buffer[idx] and then increment idx.
- After bin 15 is evaluated, the FSM SHALL go to DONE.
REQ-014 Magnitude SHALL be computed as re*re + im*im.
- re and im are sign-extended.
- Each product is 32-bit unsigned; the sum is 32-bit unsigned.
- Maximum value is 0x80000000; no overflow is possible.
REQ-015 Bin 0 SHALL load the running max and index unconditionally.
- Bins 1..15 SHALL replace them only if strictly greater (unsigned compare).
- On ties, the lowest index SHALL win.
REQ-016 freq and peak_mag SHALL update on the edge that evaluates bin 15 (FSM enters DONE).
- They SHALL hold that value until the next frame completes or reset.
- Intermediate scan values SHALL NOT appear on the outputs.
REQ-017 done SHALL be 1 exactly while the FSM is in DONE, i.e. one cycle.
REQ-018 Latency: with acceptance at edge E0, done SHALL be high between E16 and E17.
REQ-019 DONE SHALL last one cycle.
- If fft_valid=1 at E17, the block SHALL accept the new frame and go to SCAN.
- Otherwise the FSM SHALL go to IDLE.
- The minimum accepted frame spacing is 17 cycles.
REQ-020 busy SHALL be 1 exactly in SCAN.
REQ-021 fft_valid=1 while in SCAN SHALL be ignored.
- The buffer, scan and outputs SHALL be unaffected.
- drop_err SHALL be set to 1 on that edge and SHALL stay 1 until reset.
REQ-022 Data on fft_d* when fft_valid=0 SHALL be ignored, including X values.

Reset
REQ-023 While rst=1, the block SHALL asynchronously force:
- FSM=IDLE, idx=0;
- done=0, busy=0, freq=0, peak_mag=0, drop_err=0;
- buffer and running max cleared to 0.
REQ-024 Reset asserted mid-scan SHALL abort the frame: no done pulse, and outputs at reset values.
REQ-025 The first edge after rst falls SHALL be able to accept a frame.

Verification
REQ-026 Reset: assert rst asynchronously between edges -> all outputs go to 0 immediately; done stays 0 for 30 idle cycles after release.
REQ-027 Single peak: bin0={0x0100,0x0000}, other bins 0, valid at E0 -> busy high E0..E16; done high only E16..E17; freq=0, peak_mag=0x00010000.
REQ-028 Signed and tie cases:
- bin5={0x0200,0xFE00} with other bins <=0x0001 magnitude -> freq=5, peak_mag=0x00080000.
- bins 3 and 9 both {0x0300,0x0000}, rest 0 -> freq=3.
REQ-029 Extreme: bin15={0x8000,0x8000}, others {0x7FFF,0x0000} -> freq=15, peak_mag=0x80000000.
REQ-030 Drop and back-to-back:
- second valid at E8 -> ignored, drop_err=1, first result still correct at E16.
- valid at E17 -> accepted, its done at E33, drop_err unchanged.
REQ-031 Mid-scan reset: rst pulse at E10 -> no done, freq=0; a new frame after release gives the correct result with the standard 16-cycle latency.
